// File: rtl/apb_slave_pkg.sv
// Shared types and widths for the APB register-file responder.
package apb_slave_pkg;

  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned WCNT_W     = 4;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/apb_slave_regfile_resp_if.sv
// APB bus as seen between the bridge (master) and one responder (slave).
interface apb_slave_regfile_resp_if;
  import apb_slave_pkg::*;

  logic [2:0]            Pselx;
  logic                  Penable;
  logic                  Pwrite;
  logic [APB_ADDR_W-1:0] Paddr;
  logic [APB_DATA_W-1:0] Pwdata;
  logic [APB_DATA_W-1:0] Prdata;
  logic                  Pready;
  logic                  Pslverr;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );

endinterface

// File: rtl/apb_slave_regbank.sv
// DEPTH x 32-bit register bank: synchronous clear and write, combinational read.
module apb_slave_regbank
  import apb_slave_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]      ridx,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] mem_q [DEPTH];

  // Storage: cleared on reset, one word written per committed write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/apb_slave_regfile_resp.sv
// APB completer serving a DEPTH-word register bank with programmable wait states,
// slave-error reporting for bad addresses and a sticky protocol-violation flag.
module apb_slave_regfile_resp
  import apb_slave_pkg::*;
#(
  parameter int unsigned SLV_INDEX   = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                     Hclk,
  input  logic                     Hreset,
  apb_slave_regfile_resp_if.slave  apb,
  output logic                     Proto_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t                state_q, state_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic                  proto_q, proto_d;
  logic                  wr_q;
  logic                  err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [APB_DATA_W-1:0] wdata_q;
  logic [APB_DATA_W-1:0] prdata_q;

  logic                  psel;
  logic                  addr_bad;
  logic [IDX_W-1:0]      idx;
  logic [APB_DATA_W-1:0] rd_data;
  logic                  capture;
  logic                  commit;

  logic [32:0] addr_ext, base_ext, top_ext;

  // Only one select line belongs to this slave.
  logic unused_pselx;
  assign unused_pselx = ^apb.Pselx;

  assign psel = apb.Pselx[SLV_INDEX];
  assign idx  = apb.Paddr[IDX_W+1:2];

  // 33-bit compare so an aperture at the top of the address space does not wrap.
  assign addr_ext = {1'b0, apb.Paddr};
  assign base_ext = {1'b0, BASE_ADDR};
  assign top_ext  = base_ext + 33'(DEPTH * 4);
  assign addr_bad = (apb.Paddr[1:0] != 2'b00) || (addr_ext < base_ext) || (addr_ext >= top_ext);

  apb_slave_regbank #(
    .DEPTH (DEPTH)
  ) u_regbank (
    .clk   (Hclk),
    .rst   (Hreset),
    .we    (commit),
    .widx  (idx_q),
    .wdata (wdata_q),
    .ridx  (idx),
    .rdata (rd_data)
  );

  // Next-state: setup capture, wait countdown, completion and abort detection.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    proto_d = proto_q;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (psel && !apb.Penable) begin
          capture = 1'b1;
          state_d = S_ACCESS;
          wcnt_d  = WCNT_W'(WAIT_STATES);
        end else if (psel && apb.Penable) begin
          // Access phase with no preceding setup phase.
          proto_d = 1'b1;
        end
      end
      S_ACCESS: begin
        if (psel && apb.Penable) begin
          if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - 1'b1;
          end else begin
            state_d = S_IDLE;
            commit  = wr_q && !err_q;
          end
        end else begin
          // Master abandoned the transfer; a setup presented now is not taken.
          proto_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and transfer-capture registers.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      proto_q  <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      prdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      proto_q <= proto_d;
      if (capture) begin
        wr_q    <= apb.Pwrite;
        err_q   <= addr_bad;
        idx_q   <= idx;
        wdata_q <= apb.Pwdata;
        if (!apb.Pwrite) begin
          prdata_q <= addr_bad ? '0 : rd_data;
        end
      end
    end
  end

  // Registered-only outputs.
  assign apb.Pready  = (state_q == S_ACCESS) && (wcnt_q == '0);
  assign apb.Pslverr = apb.Pready && err_q;
  assign apb.Prdata  = prdata_q;
  assign Proto_err   = proto_q;

endmodule

// File: tb/tb_apb_slave_regfile_resp.sv
// Scoreboard bench: three responders share one bus, each on its own select line
// with its own wait-state count; expected responses are queued at issue time.
module tb_apb_slave_regfile_resp;

  localparam int unsigned WS0 = 0;
  localparam int unsigned WS1 = 3;
  localparam int unsigned WS2 = 2;

  logic        Hclk = 1'b0;
  logic        Hreset = 1'b1;
  logic [2:0]  pselx = 3'b000;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;

  logic [2:0]  rdy, slverr, perr;
  logic [31:0] rdat [3];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          dut;
    logic        rd;
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   acc [3];

  always #5 Hclk = ~Hclk;

  apb_slave_regfile_resp_if bus0();
  apb_slave_regfile_resp_if bus1();
  apb_slave_regfile_resp_if bus2();

  assign bus0.Pselx = pselx;  assign bus1.Pselx = pselx;  assign bus2.Pselx = pselx;
  assign bus0.Penable = penable;  assign bus1.Penable = penable;  assign bus2.Penable = penable;
  assign bus0.Pwrite = pwrite;  assign bus1.Pwrite = pwrite;  assign bus2.Pwrite = pwrite;
  assign bus0.Paddr = paddr;  assign bus1.Paddr = paddr;  assign bus2.Paddr = paddr;
  assign bus0.Pwdata = pwdata;  assign bus1.Pwdata = pwdata;  assign bus2.Pwdata = pwdata;

  assign rdy    = {bus2.Pready, bus1.Pready, bus0.Pready};
  assign slverr = {bus2.Pslverr, bus1.Pslverr, bus0.Pslverr};
  assign rdat[0] = bus0.Prdata;
  assign rdat[1] = bus1.Prdata;
  assign rdat[2] = bus2.Prdata;

  apb_slave_regfile_resp #(
    .SLV_INDEX (0), .BASE_ADDR (32'h0000_0000), .DEPTH (16), .WAIT_STATES (WS0)
  ) dut0 (
    .Hclk (Hclk), .Hreset (Hreset), .apb (bus0), .Proto_err (perr[0])
  );

  apb_slave_regfile_resp #(
    .SLV_INDEX (1), .BASE_ADDR (32'h0000_0000), .DEPTH (16), .WAIT_STATES (WS1)
  ) dut1 (
    .Hclk (Hclk), .Hreset (Hreset), .apb (bus1), .Proto_err (perr[1])
  );

  apb_slave_regfile_resp #(
    .SLV_INDEX (2), .BASE_ADDR (32'h0000_1000), .DEPTH (16), .WAIT_STATES (WS2)
  ) dut2 (
    .Hclk (Hclk), .Hreset (Hreset), .apb (bus2), .Proto_err (perr[2])
  );

  function automatic int ws_of(input int d);
    case (d)
      0:       return int'(WS0);
      1:       return int'(WS1);
      default: return int'(WS2);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts access cycles per slave and scores every completion.
  always @(negedge Hclk) begin
    for (int d = 0; d < 3; d++) begin
      if (Hreset) acc[d] = 0;
      else if (pselx[d] && penable) acc[d] = acc[d] + 1;
      else acc[d] = 0;
      if (rdy[d] && !Hreset) begin
        if (sb_q.size() == 0 || sb_q[0].dut != d) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready dut%0d: got Pready=1 expected no response", d);
        end else begin
          mon_e = sb_q.pop_front();
          check($sformatf("slverr dut%0d", d), {31'b0, slverr[d]}, {31'b0, mon_e.err});
          check($sformatf("latency dut%0d", d), acc[d], mon_e.acc);
          if (mon_e.rd) check($sformatf("prdata dut%0d", d), rdat[d], mon_e.data);
        end
      end
    end
  end

  task automatic wait_done(input int d);
    int n = 0;
    @(negedge Hclk);
    while (!rdy[d] && n < 24) begin
      @(negedge Hclk);
      n++;
    end
    if (!rdy[d]) begin
      total++;
      bad++;
      $display("FAIL timeout dut%0d: got no Pready expected completion", d);
    end
  endtask

  // Issue one transfer on select line sel, scored against slave d.
  task automatic xfer_sel(input int d, input logic [2:0] sel, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    e.dut = d; e.rd = !wr; e.data = exp_rd; e.err = exp_err; e.acc = ws_of(d) + 1;
    sb_q.push_back(e);
    @(posedge Hclk); #1;
    pselx = sel; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge Hclk); #1;
    penable = 1'b1;
    pwdata  = ~wd;  // data changes during access must be ignored
    wait_done(d);
  endtask

  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    xfer_sel(d, 3'(1 << d), wr, addr, wd, exp_rd, exp_err);
  endtask

  task automatic bus_idle();
    @(posedge Hclk); #1;
    pselx = 3'b000; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_v;

    repeat (2) @(posedge Hclk);
    @(negedge Hclk);
    check("reset_pready", {29'b0, rdy}, 32'h0);
    check("reset_pslverr", {29'b0, slverr}, 32'h0);
    check("reset_proto", {29'b0, perr}, 32'h0);
    check("reset_prdata0", rdat[0], 32'h0);
    @(posedge Hclk); #1;
    Hreset = 1'b0;

    // Write then read, no wait states, back to back.
    xfer(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Three wait states.
    xfer(1, 1'b1, 32'h4, 32'h1234_5678, 32'h0, 1'b0);
    xfer(1, 1'b0, 32'h4, 32'h0, 32'h1234_5678, 1'b0);

    // Top word, then out-of-range write, then full readback.
    xfer(0, 1'b1, 32'h3C, 32'hCAFE_F00D, 32'h0, 1'b0);
    xfer(0, 1'b1, 32'h40, 32'h5555_5555, 32'h0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      exp_v = (i == 2) ? 32'hDEAD_BEEF : (i == 15) ? 32'hCAFE_F00D : 32'h0;
      xfer(0, 1'b0, 32'(i * 4), 32'h0, exp_v, 1'b0);
    end
    xfer(0, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1);

    // Non-zero base (0x1000), two wait states, Penable dropped mid-write.
    xfer(2, 1'b1, 32'h1000, 32'hA5A5_A5A5, 32'h0, 1'b0);
    @(negedge Hclk);
    check("proto2_before", {31'b0, perr[2]}, 32'h0);
    @(posedge Hclk); #1;
    pselx = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1000; pwdata = 32'h0BAD_F00D;
    @(posedge Hclk); #1;
    penable = 1'b1;
    @(posedge Hclk); #1;
    penable = 1'b0;
    bus_idle();
    @(negedge Hclk);
    check("proto2_after_abort", {31'b0, perr[2]}, 32'h1);
    xfer(2, 1'b0, 32'h1000, 32'h0, 32'hA5A5_A5A5, 1'b0);
    xfer(2, 1'b0, 32'h0FFC, 32'h0, 32'h0, 1'b1);
    xfer(2, 1'b0, 32'h1040, 32'h0, 32'h0, 1'b1);
    xfer(2, 1'b0, 32'h103C, 32'h0, 32'h0, 1'b0);

    // Access phase with no setup phase.
    bus_idle();
    @(negedge Hclk);
    check("proto0_before", {31'b0, perr[0]}, 32'h0);
    @(posedge Hclk); #1;
    pselx = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hFFFF_FFFF;
    bus_idle();
    @(negedge Hclk);
    check("proto0_no_setup", {31'b0, perr[0]}, 32'h1);

    // Select decode: only Pselx[1] reaches dut1.
    xfer(1, 1'b1, 32'h0, 32'h1111_1111, 32'h0, 1'b0);
    xfer_sel(0, 3'b001, 1'b1, 32'h0, 32'h2222_2222, 32'h0, 1'b0);
    xfer(1, 1'b0, 32'h0, 32'h0, 32'h1111_1111, 1'b0);
    xfer(1, 1'b1, 32'h0, 32'h3333_3333, 32'h0, 1'b0);
    xfer(1, 1'b0, 32'h0, 32'h0, 32'h3333_3333, 1'b0);
    xfer(0, 1'b0, 32'h0, 32'h0, 32'h2222_2222, 1'b0);

    // Reset during the second wait cycle of a write to 0xC.
    xfer(1, 1'b1, 32'hC, 32'h7777_7777, 32'h0, 1'b0);
    @(posedge Hclk); #1;
    pselx = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h9999_9999;
    @(posedge Hclk); #1;
    penable = 1'b1;
    @(posedge Hclk); #1;
    Hreset = 1'b1;
    @(posedge Hclk); #1;
    Hreset = 1'b0; pselx = 3'b000; penable = 1'b0;
    @(negedge Hclk);
    check("reset_mid_pready1", {31'b0, rdy[1]}, 32'h0);
    check("reset_mid_proto", {29'b0, perr}, 32'h0);
    xfer(1, 1'b0, 32'hC, 32'h0, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);
    bus_idle();

    repeat (2) @(negedge Hclk);
    check("scoreboard_drained", sb_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
